// File: rtl/eightbit.sv
// eightbit: minimal 8-bit accumulator CPU with two registers (a, b), an 8-bit pc
// and an 8-bit ir, sharing one 256-byte memory over a req/ready handshake.
// Ports:
//   clk        system clock, rising-edge
//   rst        asynchronous active-low reset
//   addr       memory address of the current transaction (registered)
//   mem_ready  memory completion strobe, honoured only while mem_req=1
//   data_in    memory read data, valid with mem_ready
//   data_out   memory write data (registered, holds outside STORE)
//   mem_req    transaction request (registered)
//   we         1 = write, 0 = read (registered)
module eightbit (
    input  logic       clk,
    input  logic       rst,
    output logic [7:0] addr,
    input  logic       mem_ready,
    input  logic [7:0] data_in,
    output logic [7:0] data_out,
    output logic       mem_req,
    output logic       we
);

    localparam int unsigned DW = 8;

    localparam logic [1:0] OP_JUMP  = 2'b00;
    localparam logic [1:0] OP_LOAD  = 2'b01;
    localparam logic [1:0] OP_STORE = 2'b10;
    localparam logic [1:0] OP_ALU   = 2'b11;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_LOAD,
        S_STORE,
        S_SETTLE
    } state_t;

    state_t        state, state_nx;
    logic [DW-1:0] pc, pc_nx;
    logic [DW-1:0] ir, ir_nx;
    logic [DW-1:0] a, a_nx;
    logic [DW-1:0] b, b_nx;
    logic [DW-1:0] addr_nx, dout_nx;
    logic          req_nx, we_nx;

    // Instruction fields
    logic [1:0]    op;
    logic          rsel;
    logic [4:0]    f;
    logic [DW-1:0] data_addr;
    logic [DW-1:0] jump_addr;
    logic [DW-1:0] rsel_val;
    logic [DW-1:0] alu_res;
    logic          handshake;

    assign op        = ir[7:6];
    assign rsel      = ir[5];
    assign f         = ir[4:0];
    assign data_addr = {3'b111, f};
    assign jump_addr = {2'b00, ir[5:0]};
    assign rsel_val  = rsel ? b : a;
    assign handshake = mem_req && mem_ready;

    // ALU: 8-bit wrap-around, f[4:3] ignored
    always_comb begin
        alu_res = '0;
        case (f[2:0])
            3'b000:  alu_res = DW'(a + b);
            3'b001:  alu_res = DW'(a - b);
            3'b010:  alu_res = a & b;
            3'b011:  alu_res = a | b;
            3'b100:  alu_res = a ^ b;
            3'b101:  alu_res = ~a;
            3'b110:  alu_res = {a[6:0], 1'b0};
            default: alu_res = {1'b0, a[7:1]};
        endcase
    end

    // State register, architectural registers and registered bus outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_FETCH;
            pc       <= '0;
            ir       <= '0;
            a        <= '0;
            b        <= '0;
            addr     <= '0;
            data_out <= '0;
            mem_req  <= 1'b0;
            we       <= 1'b0;
        end else begin
            state    <= state_nx;
            pc       <= pc_nx;
            ir       <= ir_nx;
            a        <= a_nx;
            b        <= b_nx;
            addr     <= addr_nx;
            data_out <= dout_nx;
            mem_req  <= req_nx;
            we       <= we_nx;
        end
    end

    // Next-state and next-output logic; bus outputs are computed for the
    // state being entered so they are registered and glitch-free.
    always_comb begin
        state_nx = state;
        pc_nx    = pc;
        ir_nx    = ir;
        a_nx     = a;
        b_nx     = b;
        addr_nx  = addr;
        dout_nx  = data_out;
        req_nx   = 1'b0;
        we_nx    = 1'b0;

        case (state)
            S_FETCH: begin
                // Right after reset mem_req is still low: raise it first.
                if (handshake) begin
                    ir_nx    = data_in;
                    pc_nx    = DW'(pc + 8'd1);
                    state_nx = S_DECODE;
                end else begin
                    req_nx  = 1'b1;
                    addr_nx = pc;
                end
            end

            S_DECODE: begin
                case (op)
                    OP_JUMP: begin
                        pc_nx    = jump_addr;
                        addr_nx  = jump_addr;
                        req_nx   = 1'b1;
                        state_nx = S_FETCH;
                    end
                    OP_LOAD: begin
                        addr_nx  = data_addr;
                        req_nx   = 1'b1;
                        state_nx = S_LOAD;
                    end
                    OP_STORE: begin
                        addr_nx  = data_addr;
                        dout_nx  = rsel_val;
                        req_nx   = 1'b1;
                        we_nx    = 1'b1;
                        state_nx = S_STORE;
                    end
                    default: begin
                        if (rsel) begin
                            b_nx = alu_res;
                        end else begin
                            a_nx = alu_res;
                        end
                        addr_nx  = pc;
                        req_nx   = 1'b1;
                        state_nx = S_FETCH;
                    end
                endcase
            end

            S_LOAD: begin
                if (handshake) begin
                    if (rsel) begin
                        b_nx = data_in;
                    end else begin
                        a_nx = data_in;
                    end
                    state_nx = S_SETTLE;
                end else begin
                    req_nx = 1'b1;
                end
            end

            S_STORE: begin
                if (handshake) begin
                    state_nx = S_SETTLE;
                end else begin
                    req_nx = 1'b1;
                    we_nx  = 1'b1;
                end
            end

            S_SETTLE: begin
                addr_nx  = pc;
                req_nx   = 1'b1;
                state_nx = S_FETCH;
            end

            default: begin
                state_nx = S_FETCH;
            end
        endcase
    end

endmodule

// File: tb/tb_eightbit.sv
// tb_eightbit: directed bench for eightbit with a behavioural memory that
// inserts a programmable number of wait cycles per access.
module tb_eightbit;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] addr;
    logic       mem_ready = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic [7:0] data_out;
    logic       mem_req;
    logic       we;

    eightbit dut (
        .clk       (clk),
        .rst       (rst),
        .addr      (addr),
        .mem_ready (mem_ready),
        .data_in   (data_in),
        .data_out  (data_out),
        .mem_req   (mem_req),
        .we        (we)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] mem [0:255];
    logic [7:0] img [0:255];
    logic       do_load = 1'b0;
    int         wait_states = 0;

    logic [7:0] wr_addr [0:1023];
    logic [7:0] wr_data [0:1023];
    logic [7:0] rd_addr [0:4095];
    int         wr_cnt = 0;
    int         rd_cnt = 0;
    logic       just_done = 1'b0;
    int         gap_viol = 0;
    int         stab_viol = 0;

    // Memory side: completion, write commit and transaction logging
    always @(posedge clk) begin
        just_done = 1'b0;
        if (do_load) begin
            for (int i = 0; i < 256; i++) mem[i] = img[i];
        end else if (rst && mem_req && mem_ready) begin
            just_done = 1'b1;
            if (we) begin
                mem[addr] = data_out;
                if (wr_cnt < 1024) begin
                    wr_addr[wr_cnt] = addr;
                    wr_data[wr_cnt] = data_out;
                end
                wr_cnt++;
            end else begin
                if (rd_cnt < 4096) rd_addr[rd_cnt] = addr;
                rd_cnt++;
            end
        end
    end

    // Ready generation plus gap and stability monitoring
    int         wcnt = 0;
    logic       in_txn = 1'b0;
    logic [7:0] t_addr = 8'h00;
    logic [7:0] t_dout = 8'h00;
    logic       t_we = 1'b0;

    always @(negedge clk) begin
        if (just_done) begin
            if (mem_req) gap_viol++;
            mem_ready = 1'b0;
            in_txn    = 1'b0;
            wcnt      = 0;
        end else if (mem_req) begin
            if (in_txn && (addr !== t_addr || we !== t_we || data_out !== t_dout))
                stab_viol++;
            in_txn = 1'b1;
            t_addr = addr;
            t_we   = we;
            t_dout = data_out;
            if (!mem_ready) begin
                if (wcnt >= wait_states) begin
                    mem_ready = 1'b1;
                    data_in   = mem[addr];
                end else begin
                    wcnt++;
                end
            end
        end else begin
            mem_ready = 1'b0;
            in_txn    = 1'b0;
            wcnt      = 0;
        end
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic load_fib();
        for (int i = 0; i < 256; i++) img[i] = 8'h00;
        img[8'h00] = 8'h40;   // load a, E0
        img[8'h01] = 8'h62;   // load b, E2
        img[8'h02] = 8'h80;   // store a, E0
        img[8'h03] = 8'hC0;   // a = a + b
        img[8'h04] = 8'h60;   // load b, E0
        img[8'h05] = 8'h02;   // jump 02
        img[8'hE0] = 8'h01;
        img[8'hE2] = 8'h00;
    endtask

    task automatic load_alu();
        logic [7:0] prog [0:26];
        prog = '{8'h40, 8'h61, 8'hC1, 8'h82, 8'h40, 8'hC2, 8'h83, 8'h40, 8'hC3,
                 8'h84, 8'h40, 8'hC4, 8'h85, 8'h40, 8'hC5, 8'h86, 8'hE0, 8'hA7,
                 8'hC6, 8'h88, 8'hC7, 8'h89, 8'hC0, 8'h8A, 8'hD9, 8'h8B, 8'h1A};
        for (int i = 0; i < 256; i++) img[i] = 8'h00;
        for (int i = 0; i < 27; i++) img[i] = prog[i];
        img[8'hE0] = 8'h0F;
        img[8'hE1] = 8'h03;
    endtask

    // Hold reset, copy the image into memory, then release mid-low-phase
    task automatic restart(input int ws);
        rst = 1'b0;
        wait_states = ws;
        do_load = 1'b1;
        repeat (2) @(negedge clk);
        do_load = 1'b0;
        @(negedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic wait_writes(input int base, input int n, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (wr_cnt - base >= n) break;
            @(negedge clk);
        end
        chk("write_count", 16'(wr_cnt - base >= n), 16'd1);
    endtask

    logic [7:0] fib_exp [0:13] = '{8'h01, 8'h01, 8'h02, 8'h03, 8'h05, 8'h08, 8'h0D,
                                   8'h15, 8'h22, 8'h37, 8'h59, 8'h90, 8'hE9, 8'h79};
    // Stored values at E2..EB for the ALU program
    logic [7:0] alu_exp [0:9] = '{8'h0C, 8'h03, 8'h0F, 8'h0C, 8'hF0,
                                  8'hF3, 8'hE0, 8'h70, 8'h63, 8'h70};

    initial begin
        int base_w, base_r, jidx, wb;
        logic found;

        // Reset behaviour with clock running
        #1 rst = 1'b0;
        load_fib();
        do_load = 1'b1;
        repeat (3) @(negedge clk);
        do_load = 1'b0;
        #1;
        chk("rst_mem_req", 16'(mem_req), 16'h0);
        chk("rst_we", 16'(we), 16'h0);
        chk("rst_addr", 16'(addr), 16'h00);
        chk("rst_data_out", 16'(data_out), 16'h00);

        // Fibonacci, zero-wait memory
        base_w = wr_cnt;
        base_r = rd_cnt;
        wait_states = 0;
        rst = 1'b1;
        @(negedge clk);
        #1;
        chk("first_req", 16'(mem_req), 16'h1);
        chk("first_we", 16'(we), 16'h0);
        chk("first_addr", 16'(addr), 16'h00);
        wait_writes(base_w, 14, 1000);
        for (int k = 0; k < 14; k++)
            chk($sformatf("fib0_w%0d", k), {wr_addr[base_w+k], wr_data[base_w+k]},
                {8'hE0, fib_exp[k]});

        found = 1'b0;
        jidx = 0;
        for (int i = base_r; i < rd_cnt - 1; i++) begin
            if (!found && rd_addr[i] == 8'h05) begin
                found = 1'b1;
                jidx = i;
            end
        end
        chk("jump_seen", 16'(found), 16'h1);
        if (found) chk("jump_target", 16'(rd_addr[jidx+1]), 16'h02);

        // Fibonacci with three wait cycles per access
        load_fib();
        restart(3);
        base_w = wr_cnt;
        wait_writes(base_w, 14, 4000);
        for (int k = 0; k < 14; k++)
            chk($sformatf("fib3_w%0d", k), {wr_addr[base_w+k], wr_data[base_w+k]},
                {8'hE0, fib_exp[k]});

        // Reset in the middle of a pending store
        found = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            #2;
            if (mem_req && we && !mem_ready) begin
                found = 1'b1;
                break;
            end
        end
        chk("store_pending", 16'(found), 16'h1);
        wb = wr_cnt;
        rst = 1'b0;
        #1;
        chk("abort_mem_req", 16'(mem_req), 16'h0);
        chk("abort_we", 16'(we), 16'h0);
        repeat (6) @(negedge clk);
        chk("abort_no_write", 16'(wr_cnt - wb), 16'h0);

        // ALU operations, one wait cycle per access
        load_alu();
        restart(1);
        base_w = wr_cnt;
        wait_writes(base_w, 10, 2000);
        repeat (20) @(negedge clk);
        chk("alu_writes", 16'(wr_cnt - base_w), 16'd10);
        for (int k = 0; k < 10; k++)
            chk($sformatf("alu_E%0h", 8'hE2 + k), 16'(mem[8'hE2 + k]), 16'(alu_exp[k]));

        chk("handshake_gap", 16'(gap_viol), 16'h0);
        chk("bus_stable", 16'(stab_viol), 16'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
